// File: rtl/ila_trigger_gen.sv
// ila_trigger_gen: masked pattern trigger with consecutive-match
// qualification and post-arm holdoff, feeding an ILA capture input.
// data_out stays zero until the trigger fires, then carries registered probe data.
module ila_trigger_gen #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned RUN_WIDTH     = 4,
    parameter int unsigned HOLDOFF_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    probe_in,
    input  logic                     probe_valid,
    input  logic [DATA_WIDTH-1:0]    cfg_pattern,
    input  logic [DATA_WIDTH-1:0]    cfg_mask,
    input  logic [RUN_WIDTH-1:0]     cfg_match_count,
    input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff,
    input  logic                     arm,
    input  logic                     disarm,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic                     trig_out,
    output logic [1:0]               state_out,
    output logic [15:0]              trig_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLDOFF = 2'd1,
        S_ARMED   = 2'd2,
        S_FIRED   = 2'd3
    } state_e;

    localparam logic [RUN_WIDTH-1:0]     RUN_ONE   = RUN_WIDTH'(1);
    localparam logic [RUN_WIDTH:0]       NEED_ONE  = (RUN_WIDTH + 1)'(1);
    localparam logic [HOLDOFF_WIDTH-1:0] HOLD_ONE  = HOLDOFF_WIDTH'(1);
    localparam logic [15:0]              COUNT_ONE = 16'd1;

    state_e                   state_q, state_d;
    logic [RUN_WIDTH-1:0]     run_q, run_d;
    logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     trig_q, trig_d;
    logic [15:0]              count_q, count_d;

    logic                 match;
    logic                 fire;
    logic [RUN_WIDTH:0]   run_plus1;
    logic [RUN_WIDTH:0]   need;
    logic [RUN_WIDTH-1:0] run_upd;

    assign match     = probe_valid && (((probe_in ^ cfg_pattern) & cfg_mask) == '0);
    // Widened by one bit so an all-ones run plus the current match cannot wrap.
    assign run_plus1 = {1'b0, run_q} + NEED_ONE;
    assign need      = (cfg_match_count == '0) ? NEED_ONE : {1'b0, cfg_match_count};
    assign fire      = match && (run_plus1 >= need);

    // Next-state, match-run and capture-word logic.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        valid_d = valid_q;
        trig_d  = 1'b0;
        count_d = count_q;

        // Match run: saturating increment on valid match, clear on valid miss,
        // hold across invalid samples.
        run_upd = run_q;
        if (probe_valid) begin
            if (match) begin
                run_upd = (&run_q) ? run_q : run_q + RUN_ONE;
            end else begin
                run_upd = '0;
            end
        end
        run_d = run_upd;

        if (disarm) begin
            state_d = S_IDLE;
            hold_d  = '0;
            data_d  = '0;
            valid_d = 1'b0;
            run_d   = '0;
        end else if (arm) begin
            // Arm wins over a simultaneous fire: a re-arm always restarts qualification.
            data_d  = '0;
            valid_d = 1'b0;
            if (cfg_holdoff == '0) begin
                state_d = S_ARMED;
                hold_d  = '0;
                run_d   = '0;
            end else begin
                state_d = S_HOLDOFF;
                hold_d  = cfg_holdoff;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    data_d  = '0;
                    valid_d = 1'b0;
                end
                S_HOLDOFF: begin
                    data_d  = '0;
                    valid_d = 1'b0;
                    if (hold_q <= HOLD_ONE) begin
                        state_d = S_ARMED;
                        hold_d  = '0;
                        run_d   = '0;
                    end else begin
                        hold_d = hold_q - HOLD_ONE;
                    end
                end
                S_ARMED: begin
                    data_d  = '0;
                    valid_d = 1'b0;
                    if (fire) begin
                        state_d = S_FIRED;
                        data_d  = probe_in;
                        valid_d = 1'b1;
                        trig_d  = 1'b1;
                        count_d = (&count_q) ? count_q : count_q + COUNT_ONE;
                    end
                end
                S_FIRED: begin
                    if (probe_valid) begin
                        data_d  = probe_in;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    data_d  = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            run_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            trig_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            trig_q  <= trig_d;
            count_q <= count_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign trig_out   = trig_q;
    assign state_out  = state_q;
    assign trig_count = count_q;

endmodule

// File: tb/tb_ila_trigger_gen.sv
// Testbench for ila_trigger_gen: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
module tb_ila_trigger_gen;

    localparam int DW = 64;
    localparam int RW = 4;
    localparam int HW = 8;
    localparam int RUN_MAX = (1 << RW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] probe_in;
    logic          probe_valid;
    logic [DW-1:0] cfg_pattern;
    logic [DW-1:0] cfg_mask;
    logic [RW-1:0] cfg_match_count;
    logic [HW-1:0] cfg_holdoff;
    logic          arm;
    logic          disarm;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          trig_out;
    logic [1:0]    state_out;
    logic [15:0]   trig_count;

    ila_trigger_gen #(
        .DATA_WIDTH   (DW),
        .RUN_WIDTH    (RW),
        .HOLDOFF_WIDTH(HW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .probe_in       (probe_in),
        .probe_valid    (probe_valid),
        .cfg_pattern    (cfg_pattern),
        .cfg_mask       (cfg_mask),
        .cfg_match_count(cfg_match_count),
        .cfg_holdoff    (cfg_holdoff),
        .arm            (arm),
        .disarm         (disarm),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .trig_out       (trig_out),
        .state_out      (state_out),
        .trig_count     (trig_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Behavioural model: state as a small integer (0 idle, 1 holdoff,
    // 2 armed, 3 fired), holdoff as cycles remaining, run as a plain count.
    int          m_state = 0;
    int          m_run = 0;
    int          m_hold_left = 0;
    int          m_cnt = 0;
    logic [63:0] m_data = '0;
    bit          m_dv = 1'b0;
    bit          m_trig = 1'b0;

    always @(posedge clk) begin : model
        bit mt;
        int need;
        int run_next;
        mt = probe_valid && (((probe_in ^ cfg_pattern) & cfg_mask) == 64'd0);
        need = (cfg_match_count == 0) ? 1 : int'(cfg_match_count);
        run_next = m_run;
        if (probe_valid) run_next = mt ? ((m_run < RUN_MAX) ? m_run + 1 : RUN_MAX) : 0;
        m_trig = 1'b0;
        if (reset) begin
            m_state = 0; m_run = 0; m_hold_left = 0; m_cnt = 0; m_data = '0; m_dv = 1'b0;
        end else if (disarm) begin
            m_state = 0; m_run = 0; m_hold_left = 0; m_data = '0; m_dv = 1'b0;
        end else if (arm) begin
            m_data = '0; m_dv = 1'b0;
            if (cfg_holdoff == 0) begin
                m_state = 2; m_run = 0;
            end else begin
                m_state = 1; m_hold_left = int'(cfg_holdoff); m_run = run_next;
            end
        end else begin
            case (m_state)
                1: begin
                    m_hold_left = m_hold_left - 1;
                    if (m_hold_left == 0) begin m_state = 2; m_run = 0; end
                    else m_run = run_next;
                end
                2: begin
                    if (mt && (m_run + 1 >= need)) begin
                        m_state = 3; m_data = probe_in; m_dv = 1'b1; m_trig = 1'b1;
                        if (m_cnt < 65535) m_cnt = m_cnt + 1;
                    end
                    m_run = run_next;
                end
                3: begin
                    if (probe_valid) begin m_data = probe_in; m_dv = 1'b1; end
                    else m_dv = 1'b0;
                    m_run = run_next;
                end
                default: m_run = run_next;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp data_out", data_out, m_data);
            chk("cmp data_valid", 64'(data_valid), 64'(m_dv));
            chk("cmp trig_out", 64'(trig_out), 64'(m_trig));
            chk("cmp state_out", 64'(state_out), 64'(m_state));
            chk("cmp trig_count", 64'(trig_count), 64'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] words [7];
        bit          wvalid [7];
        logic [7:0]  lows [7];
        logic [63:0] p;
        int          exp_cnt;

        reset = 1'b1; probe_in = '0; probe_valid = 1'b0;
        cfg_pattern = '0; cfg_mask = '0; cfg_match_count = '0; cfg_holdoff = '0;
        arm = 1'b0; disarm = 1'b0;

        // Reset with toggling probe.
        for (int i = 0; i < 2; i++) begin
            probe_in = {$urandom, $urandom}; probe_valid = i[0];
            step();
            cmp_en = 1'b1;
        end
        chk("reset data_out", data_out, 64'd0);
        chk("reset data_valid", 64'(data_valid), 64'd0);
        chk("reset trig_out", 64'(trig_out), 64'd0);
        chk("reset state_out", 64'(state_out), 64'd0);
        chk("reset trig_count", 64'(trig_count), 64'd0);
        reset = 1'b0; probe_valid = 1'b0;
        step();

        // Basic fire, full mask.
        cfg_pattern = 64'hDEAD_BEEF_0000_0001; cfg_mask = '1; cfg_match_count = 4'd1; cfg_holdoff = '0;
        arm = 1'b1;
        step();
        chk("basic armed state", 64'(state_out), 64'd2);
        arm = 1'b0; probe_valid = 1'b1;
        probe_in = 64'h1; step();
        chk("basic no early fire", 64'(trig_out), 64'd0);
        probe_in = 64'h2; step();
        probe_in = 64'hDEAD_BEEF_0000_0001; step();
        chk("basic trig_out", 64'(trig_out), 64'd1);
        chk("basic data_out", data_out, 64'hDEAD_BEEF_0000_0001);
        chk("basic state fired", 64'(state_out), 64'd3);
        chk("basic trig_count", 64'(trig_count), 64'd1);
        probe_in = 64'h0000_0000_0000_1234; step();
        chk("basic passthrough", data_out, 64'h1234);
        chk("basic single pulse", 64'(trig_out), 64'd0);

        // Consecutive matches with partial mask and an invalid gap.
        disarm = 1'b1; step(); disarm = 1'b0;
        cfg_mask = 64'hFF; cfg_pattern = 64'h5A; cfg_match_count = 4'd3; probe_valid = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
        lows = '{8'h5A, 8'h5A, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        wvalid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            words[i] = {$urandom, $urandom_range(0, 32'hFF_FFFF), lows[i]};
            probe_in = words[i]; probe_valid = wvalid[i];
            step();
            if (i < 6) begin
                chk("run no fire", 64'(trig_out), 64'd0);
                chk("run data zero", data_out, 64'd0);
            end else begin
                chk("run fire 7th", 64'(trig_out), 64'd1);
                chk("run fire data", data_out, words[6]);
                chk("run trig_count", 64'(trig_count), 64'd2);
            end
        end

        // Holdoff of 4 with a constantly matching probe.
        disarm = 1'b1; step(); disarm = 1'b0;
        cfg_holdoff = 8'd4; cfg_match_count = 4'd1; probe_in = 64'h5A; probe_valid = 1'b1;
        arm = 1'b1; step(); arm = 1'b0;
        chk("holdoff cycle 1", 64'(state_out), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("holdoff cycles 2-4", 64'(state_out), 64'd1);
        end
        step();
        chk("holdoff armed", 64'(state_out), 64'd2);
        chk("holdoff no trig yet", 64'(trig_out), 64'd0);
        step();
        chk("holdoff trig", 64'(trig_out), 64'd1);
        chk("holdoff trig_count", 64'(trig_count), 64'd3);

        // Abort and priority.
        disarm = 1'b1; step(); disarm = 1'b0;
        chk("disarm data_out", data_out, 64'd0);
        chk("disarm data_valid", 64'(data_valid), 64'd0);
        chk("disarm state", 64'(state_out), 64'd0);
        arm = 1'b1; disarm = 1'b1; step(); arm = 1'b0; disarm = 1'b0;
        chk("arm+disarm idle", 64'(state_out), 64'd0);
        p = 64'hCAFE_F00D_1234_5678;
        cfg_holdoff = '0; cfg_mask = '1; cfg_pattern = p; probe_in = p;
        arm = 1'b1; step(); arm = 1'b0;
        step();
        chk("abort fire", 64'(trig_out), 64'd1);
        disarm = 1'b1; step(); disarm = 1'b0;
        chk("fired disarm data", data_out, 64'd0);
        arm = 1'b1; step(); arm = 1'b0;
        step();
        chk("re-arm fire", 64'(trig_out), 64'd1);
        chk("re-arm trig_count", 64'(trig_count), 64'd5);

        // Reset while fired clears everything including the count.
        reset = 1'b1; step(); reset = 1'b0;
        chk("reset fired count", 64'(trig_count), 64'd0);
        chk("reset fired state", 64'(state_out), 64'd0);
        chk("reset fired data", data_out, 64'd0);

        // Saturation: preload the counter near the top, then keep firing.
        cfg_mask = '0; cfg_holdoff = '0; cfg_match_count = 4'd1;
        force dut.count_q = 16'hFFFC;
        m_cnt = 65532;
        release dut.count_q;
        exp_cnt = 65532;
        for (int i = 0; i < 4; i++) begin
            probe_in = {$urandom, $urandom}; probe_valid = 1'b1;
            arm = 1'b1; step(); arm = 1'b0;
            step();
            exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
            chk("sat trig", 64'(trig_out), 64'd1);
            chk("sat count", 64'(trig_count), 64'(exp_cnt));
        end
        chk("sat final", 64'(trig_count), 64'hFFFF);

        // Randomized traffic; configuration only changes while idle.
        for (int i = 0; i < 4000; i++) begin
            if (m_state == 0 && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: cfg_mask = '0;
                    1: cfg_mask = 64'hFF;
                    2: cfg_mask = {$urandom, $urandom};
                    default: cfg_mask = '1;
                endcase
                cfg_pattern = {$urandom, $urandom};
                cfg_match_count = RW'($urandom_range(0, 5));
                cfg_holdoff = HW'($urandom_range(0, 5));
            end
            probe_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) probe_in = cfg_pattern ^ ({$urandom, $urandom} & ~cfg_mask);
            else probe_in = {$urandom, $urandom};
            arm = ($urandom_range(0, 19) == 0);
            disarm = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        arm = 1'b0; disarm = 1'b0; reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
